// File: rtl/fft_window_stream.sv
// Window stage in front of the FFT core: each complex beat of point k is scaled by w[k].
// Two-stage AXI-Stream pipeline (multiply, round/saturate) with framing-error detection and bypass.
module fft_window_stream #(
    parameter int NFFT       = 3,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bypass,
    input  logic [NFFT-1:0]       coefWAddr,
    input  logic [COEF_WIDTH-1:0] coefWData,
    input  logic                  coefWEn,
    input  logic                  errClr,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [63:0]           s_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [63:0]           m_axis_tdata,
    output logic                  frameErr,
    output logic                  busy
);
    localparam int N  = 2 ** NFFT;
    localparam int PW = 32 + COEF_WIDTH + 1;
    localparam int RW = PW - COEF_WIDTH + 1;
    localparam logic [COEF_WIDTH-1:0] COEF_ONE = {1'b1, {(COEF_WIDTH-1){1'b0}}};
    localparam logic [NFFT-1:0]       IDX_LAST = NFFT'(N - 1);
    localparam logic [PW-1:0]         RND_HALF = PW'(1) << (COEF_WIDTH - 2);

    typedef struct packed {
        logic          valid;
        logic          last;
        logic [PW-1:0] p_re;
        logic [PW-1:0] p_im;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [63:0] data;
    } s2_t;

    // Low PW bits of the product are exact two's complement for signed data times unsigned coef.
    function automatic logic [PW-1:0] mul(input logic [31:0] d, input logic [COEF_WIDTH-1:0] c);
        mul = PW'($signed(d)) * PW'({1'b0, c});
    endfunction

    function automatic logic [31:0] round_sat(input logic [PW-1:0] p);
        logic [PW-1:0] sum;
        logic [RW-1:0] r;
        sum = p + RND_HALF;
        r   = sum[PW-1:COEF_WIDTH-1];
        if (!r[RW-1] && (r[RW-2:31] != '0))
            round_sat = 32'h7FFF_FFFF;
        else if (r[RW-1] && (r[RW-2:31] != '1))
            round_sat = 32'h8000_0000;
        else
            round_sat = r[31:0];
    endfunction

    logic                  ready_q, ready_d;
    logic [NFFT-1:0]       idx_q, idx_d;
    logic                  frame_err_q, frame_err_d;
    logic [COEF_WIDTH-1:0] w_q [N];
    logic [COEF_WIDTH-1:0] w_d [N];
    s1_t                   s1_q, s1_d;
    s2_t                   s2_q, s2_d;

    logic                  en;
    logic                  accept;
    logic                  idx_last;
    logic [COEF_WIDTH-1:0] coef;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        ready_d       = 1'b1;
        en            = !s2_q.valid || m_axis_tready;
        s_axis_tready = ready_q && en;
        accept        = s_axis_tvalid && s_axis_tready;
        idx_last      = (idx_q == IDX_LAST);
        // Read of w_q sees the pre-write value, so a same-cycle write is used from the next beat.
        coef          = bypass ? COEF_ONE : w_q[idx_q];

        w_d = w_q;
        if (coefWEn)
            w_d[coefWAddr] = coefWData;

        idx_d = idx_q;
        if (accept)
            idx_d = (s_axis_tlast || idx_last) ? '0 : idx_q + 1'b1;

        frame_err_d = frame_err_q;
        if (errClr)
            frame_err_d = 1'b0;
        if (accept && (s_axis_tlast != idx_last))
            frame_err_d = 1'b1;

        s1_d = s1_q;
        s2_d = s2_q;
        if (en) begin
            s1_d.valid = accept;
            s1_d.last  = s_axis_tlast;
            s1_d.p_re  = mul(s_axis_tdata[31:0], coef);
            s1_d.p_im  = mul(s_axis_tdata[63:32], coef);
            s2_d.valid = s1_q.valid;
            s2_d.last  = s1_q.last;
            s2_d.data  = {round_sat(s1_q.p_im), round_sat(s1_q.p_re)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            idx_q       <= '0;
            frame_err_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            // NOTE: the coefficient array is a register file that must come up at 1.0, so it is reset.
            for (int k = 0; k < N; k++)
                w_q[k] <= COEF_ONE;
        end else begin
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            w_q         <= w_d;
        end
    end

    assign m_axis_tvalid = s2_q.valid;
    assign m_axis_tlast  = s2_q.last;
    assign m_axis_tdata  = s2_q.data;
    assign frameErr      = frame_err_q;
    assign busy          = s1_q.valid || s2_q.valid || (idx_q != '0);

endmodule
